// File: rtl/eyeriss_pe.sv
// Row-stationary Eyeriss processing element: holds one filter row, slides a
// stride-1 ifmap window and emits one serially accumulated dot product per output.
module eyeriss_pe #(
  parameter int DATA_W      = 8,
  parameter int FILT_LEN    = 3,
  parameter int PSUM_W      = 16,
  parameter int CNT_W       = 8,
  parameter int SATURATE    = 0,
  parameter int USE_PSUM_IN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_out,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] if_data,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [PSUM_W-1:0] ps_in_data,
  input  logic              ps_in_valid,
  output logic              ps_in_ready,
  output logic [PSUM_W-1:0] ps_out_data,
  output logic              ps_out_valid,
  input  logic              ps_out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILT_LEN - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_W = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] MAC    = 3'd3;
  localparam logic [2:0] ACC    = 3'd4;
  localparam logic [2:0] OUT    = 3'd5;
  localparam logic [2:0] SLIDE  = 3'd6;
  localparam logic [2:0] FIN    = 3'd7;

  logic [2:0]               state;
  logic [CNT_W-1:0]         n_reg;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] w_spad [FILT_LEN];
  logic signed [DATA_W-1:0] x_win  [FILT_LEN];
  logic signed [PSUM_W-1:0] acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [PSUM_W-1:0] prod_ext;

  // One extra guard bit detects overflow; clamping only when SATURATE is set.
  function automatic logic signed [PSUM_W-1:0] sat_add(
    input logic signed [PSUM_W-1:0] a,
    input logic signed [PSUM_W-1:0] b
  );
    logic [PSUM_W:0] s;
    s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
    if ((SATURATE != 0) && (s[PSUM_W] != s[PSUM_W-1])) begin
      if (s[PSUM_W])
        return {1'b1, {(PSUM_W-1){1'b0}}};
      else
        return {1'b0, {(PSUM_W-1){1'b1}}};
    end
    return s[PSUM_W-1:0];
  endfunction

  assign prod     = w_spad[idx] * x_win[idx];
  assign prod_ext = PSUM_W'(prod);
  assign cnt_next = cnt + 1'b1;

  assign w_ready      = (state == LOAD_W);
  assign if_ready     = (state == FILL) || (state == SLIDE);
  assign ps_in_ready  = (USE_PSUM_IN != 0) && (state == ACC);
  assign ps_out_valid = (state == OUT);
  assign ps_out_data  = ps_out_valid ? acc : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);

  // idx doubles as weight-load, window-fill and MAC tap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n_reg <= '0;
      cnt   <= '0;
      idx   <= '0;
      acc   <= '0;
      for (int i = 0; i < FILT_LEN; i++) begin
        w_spad[i] <= '0;
        x_win[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg <= num_out;
            cnt   <= '0;
            idx   <= '0;
            state <= (num_out == '0) ? FIN : LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_valid && w_ready) begin
            w_spad[idx] <= w_data;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= FILL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FILL: begin
          if (if_valid && if_ready) begin
            for (int i = 0; i < FILT_LEN - 1; i++) x_win[i] <= x_win[i+1];
            x_win[FILT_LEN-1] <= if_data;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= MAC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        MAC: begin
          acc <= sat_add((idx == '0) ? '0 : acc, prod_ext);
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= (USE_PSUM_IN != 0) ? ACC : OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ACC: begin
          if (ps_in_valid && ps_in_ready) begin
            acc   <= sat_add(acc, ps_in_data);
            state <= OUT;
          end
        end
        OUT: begin
          if (ps_out_ready) begin
            cnt   <= cnt_next;
            state <= (cnt_next == n_reg) ? FIN : SLIDE;
          end
        end
        SLIDE: begin
          if (if_valid && if_ready) begin
            for (int i = 0; i < FILT_LEN - 1; i++) x_win[i] <= x_win[i+1];
            x_win[FILT_LEN-1] <= if_data;
            state <= MAC;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eyeriss_pe.md
Name: eyeriss_pe

Overview:
Parametrised row-stationary processing element (PE), the compute tile of the Eyeriss array behind the TinyTapeout top level. It holds one filter row in a weight scratchpad and slides a stride-1 ifmap window over an input row. Each output is a dot product accumulated serially, one MAC per cycle, plus an optional vertical partial sum from the neighbouring PE. Every stream uses a valid/ready handshake.

Parameters:
DATA_W, 8, signed width of weights and ifmap activations
FILT_LEN, 3, filter row length S (>=2); depth of weight and ifmap scratchpads
PSUM_W, 16, signed accumulator and psum width (>= 2*DATA_W)
CNT_W, 8, width of the output-count config field
SATURATE, 0, 0 = two's-complement wrap on overflow; 1 = clamp to signed PSUM_W min/max
USE_PSUM_IN, 1, 1 = add the ps_in operand before output; 0 = ps_in ignored, ps_in_ready held 0

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  asynchronous reset, active high
start  in  1  single-cycle pulse that begins a row; honoured only in IDLE
num_out  in  CNT_W  outputs to produce this row; sampled on start
w_data  in  DATA_W  weight word
w_valid  in  1  weight valid
w_ready  out  1  PE accepts a weight
if_data  in  DATA_W  ifmap word
if_valid  in  1  ifmap valid
if_ready  out  1  PE accepts an ifmap word
ps_in_data  in  PSUM_W  incoming partial sum
ps_in_valid  in  1  incoming partial sum valid
ps_in_ready  out  1  PE accepts the partial sum
ps_out_data  out  PSUM_W  result partial sum
ps_out_valid  out  1  result valid
ps_out_ready  in  1  downstream accepts the result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the row completes

Behaviour:
- Reset (async, rst=1): state=IDLE. Every output is 0: w_ready, if_ready, ps_in_ready, ps_out_valid, ps_out_data, busy, done. Scratchpads, accumulator and counters clear. Reset asserted mid-row aborts the row with no done pulse.
- A transfer occurs only on a cycle where valid=1 and ready=1 at the clock edge. ps_out_data is stable while ps_out_valid=1 and ps_out_ready=0.
- IDLE: on start, latch N=num_out and clear cnt. If N=0, go to FIN; otherwise go to LOAD_W. start outside IDLE is ignored.
- LOAD_W: w_ready=1. Accept FILT_LEN weights into w_spad[0..S-1] in arrival order, then go to FILL.
- FILL: if_ready=1. Accept S words into the window: each new word enters x[S-1] and x[k] shifts to x[k-1]. After S words, go to MAC.
- MAC: runs exactly S cycles, k=0..S-1. The accumulator clears on entry; each cycle acc += w[k]*x[k]. The product is a full 2*DATA_W signed value, sign-extended to PSUM_W. After S cycles, go to ACC if USE_PSUM_IN=1, otherwise to OUT.
- ACC: ps_in_ready=1. On handshake, acc += ps_in_data, then go to OUT. The PE waits indefinitely for ps_in_valid.
- Overflow handling applies to every addition. With SATURATE=0 the result wraps modulo 2^PSUM_W. With SATURATE=1 each addition clamps to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1] and later additions start from the clamped value.
- OUT: ps_out_valid=1 and ps_out_data=acc. On handshake, cnt++. If cnt equals N, go to FIN; otherwise go to SLIDE.
- SLIDE: if_ready=1. Accept one word, shifted into the window exactly as in FILL, then go to MAC.
- FIN: done=1 for one cycle, then return to IDLE. busy is 1 in FIN.
- Only the state's own ready or valid is ever high; all other handshake outputs stay 0.
- Timing per output (zero-stall): S MAC cycles, plus 1 ACC cycle, plus 1 OUT cycle. The first output needs S weight words and S fill words before it. Each later output needs 1 SLIDE word before it.
- N-output row: the ifmap stream supplies exactly S+N-1 words.

Test Plan:
1. S=3, SATURATE=0, weights 1,2,3; ifmap 1..5; N=3; ps_in 0,0,0; ps_out_ready=1 -> ps_out 14, 20, 26, then one done pulse and busy=0.
2. Same as scenario 1 with ps_in 100, -20, 5 -> ps_out 114, 0, 31. With USE_PSUM_IN=0 -> 14, 20, 26 and ps_in_ready never 1.
3. PSUM_W=16, weights 127,127,127; ifmap 127,127,127; N=1. SATURATE=0 -> ps_out -17149. SATURATE=1 -> 32767. Repeat with weights -128 and ifmap 127 under SATURATE=1 -> -32768.
4. Backpressure: hold ps_out_ready=0 for 5 cycles in scenario 1 -> ps_out_valid stays 1, data 14 held stable, if_ready=0, no extra ifmap consumed. Throttle w_valid and if_valid randomly -> same results.
5. N=0 with start -> done 2 cycles after start, no ready ever raised. A start pulse while busy is ignored.
6. Assert rst during MAC of the second output -> all outputs 0 immediately, no done pulse. A new start then reproduces scenario 1 exactly.
